// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple-carry slice once per cycle, least
// significant nibble first, with a start/busy/done handshake.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q, res_q, sum_q;
  logic            carry_q, cout_q, ovf_q;
  logic [IdxW-1:0] idx_q;

  logic [3:0] rca_x, rca_y, rca_s;
  logic [4:0] rca_c;
  logic       rca_cout;
  logic       last;

  // Nibble mux feeding the single shared slice.
  always_comb begin
    rca_x = a_q[{idx_q, 2'b00} +: 4];
    rca_y = b_q[{idx_q, 2'b00} +: 4];
  end

  // 4-bit ripple-carry slice.
  always_comb begin
    rca_c    = '0;
    rca_s    = '0;
    rca_c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      rca_s[i]   = rca_x[i] ^ rca_y[i] ^ rca_c[i];
      rca_c[i+1] = (rca_x[i] & rca_y[i]) | (rca_c[i] & (rca_x[i] ^ rca_y[i]));
    end
    rca_cout = rca_c[4];
  end

  assign last = (idx_q == IdxW'(NIBBLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        StRun: begin
          res_q[{idx_q, 2'b00} +: 4] <= rca_s;
          carry_q                    <= rca_cout;
          if (last) begin
            // Publish the whole word at once so partial results never show.
            sum_q  <= {rca_s, res_q[W-5:0]};
            cout_q <= rca_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (rca_s[3] != a_q[W-1]);
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
